// File: rtl/regfile_pkg.sv
// Shared constants for the register file: default geometry and the index of
// the hardwired zero register.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

endpackage : regfile_pkg

// File: rtl/regfile.sv
// Two-read, one-write register file with register 0 hardwired to zero,
// combinational reads (no write bypass) and an asynchronous clear.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WE,
  input  logic [ADDR_W-1:0] rW,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  input  logic [DATA_W-1:0] W,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam int                NUM_REGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_en;

  // An X/Z write enable evaluates false here, so an unknown WE never writes.
  assign wr_en = (WE == 1'b1) && (rW != ZERO_ADDR);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[rW] = W;
    end
    regs_d[ZERO_ADDR] = '0;
  end

  // NOTE: the array is reset as a whole because the clear must be asynchronous
  // and visible on every address; this rules out mapping onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the storage, so a same-cycle write shows up only
  // after the edge that commits it.
  always_comb begin
    A = '0;
    B = '0;
    if (rA != ZERO_ADDR) begin
      A = regs_q[rA];
    end
    if (rB != ZERO_ADDR) begin
      B = regs_q[rB];
    end
  end

endmodule : regfile

// File: tb/tb_regfile.sv
// Directed bench for regfile: stimulus pushes hand-computed read expectations
// into a scoreboard queue, and a monitor process pops and compares them.
module tb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              WE;
  logic [ADDR_W-1:0] rW;
  logic [ADDR_W-1:0] rA;
  logic [ADDR_W-1:0] rB;
  logic [DATA_W-1:0] W;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;

  exp_t sb_q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .WE    (WE),
    .rW    (rW),
    .rA    (rA),
    .rB    (rB),
    .W     (W),
    .A     (A),
    .B     (B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue an expectation for the current rA/rB and hand it to the monitor.
  task automatic expect_rd(input string name, input logic [DATA_W-1:0] ea,
                           input logic [DATA_W-1:0] eb);
    exp_t e;
    e.name = name;
    e.a    = ea;
    e.b    = eb;
    sb_q.push_back(e);
    ->chk_ev;
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_A"}, A, e.a);
        check({e.name, "_B"}, B, e.b);
      end
    end
  end

  task automatic drive(input logic we, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra,
                       input logic [ADDR_W-1:0] rb);
    WE = we;
    rW = wa;
    W  = wd;
    rA = ra;
    rB = rb;
  endtask

  initial begin : stimulus
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);

    // Asynchronous clear before any clock edge has occurred.
    #1 rst_n = 1'b0;
    expect_rd("reset_async", 32'h0, 32'h0);

    // Writes are blocked while reset is held across edges.
    @(negedge clk);
    drive(1'b1, 5'd1, 32'hFFFF_FFFF, 5'd1, 5'd2);
    @(posedge clk);
    @(posedge clk);
    expect_rd("write_in_reset", 32'h0, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd1, 32'hFFFF_FFFF, 5'd1, 5'd2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      expect_rd("we_low_hold", 32'h0, 32'h0);
    end

    // Write reg1: old value visible before the edge, new value after it.
    @(negedge clk);
    drive(1'b1, 5'd1, 32'hFFFF_FFFF, 5'd1, 5'd2);
    expect_rd("pre_edge_old", 32'h0, 32'h0);
    @(posedge clk);
    expect_rd("wr_reg1", 32'hFFFF_FFFF, 32'h0);

    @(negedge clk);
    drive(1'b1, 5'd2, 32'h8888_8888, 5'd1, 5'd2);
    @(posedge clk);
    expect_rd("wr_reg2", 32'hFFFF_FFFF, 32'h8888_8888);

    // Register 0 ignores writes.
    @(negedge clk);
    drive(1'b1, 5'd0, 32'h8888_8888, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      expect_rd("zero_reg", 32'h0, 32'h0);
    end

    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
    expect_rd("same_addr", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // A write to reg 31 leaves its neighbours alone.
    @(negedge clk);
    drive(1'b1, 5'd31, 32'h1234_5678, 5'd31, 5'd2);
    @(posedge clk);
    expect_rd("wr_reg31", 32'h1234_5678, 32'h8888_8888);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd30);
    expect_rd("neighbours", 32'hFFFF_FFFF, 32'h0);

    // Reset pulse between edges clears the array; the next write works.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    #1 rst_n = 1'b0;
    expect_rd("mid_reset", 32'h0, 32'h0);
    rst_n = 1'b1;
    expect_rd("after_pulse", 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd1);
    @(posedge clk);
    expect_rd("wr_after_reset", 32'hA5A5_A5A5, 32'h0);

    // A reset overlapping the edge discards that cycle's write.
    @(negedge clk);
    drive(1'b1, 5'd4, 32'hDEAD_BEEF, 5'd4, 5'd3);
    #1 rst_n = 1'b0;
    @(posedge clk);
    expect_rd("pending_discard", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd4, 32'hDEAD_BEEF, 5'd4, 5'd3);
    @(posedge clk);
    expect_rd("after_discard", 32'h0, 32'h0);

    // Bounded drain of the scoreboard before the summary.
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
      #1;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_W, default 32: width of each register and of the write and read data ports.
REQ-002 Parameter ADDR_W, default 5: register address width; the register count is 2**ADDR_W (32 by default).
REQ-003 Port clk, input, 1 bit: single clock; all writes occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port WE, input, 1 bit: write enable, active-high.
REQ-006 Port rW, input, ADDR_W bits: write address.
REQ-007 Port rA, input, ADDR_W bits: read port A address.
REQ-008 Port rB, input, ADDR_W bits: read port B address.
REQ-009 Port W, input, DATA_W bits: write data.
REQ-010 Port A, output, DATA_W bits: read port A data.
REQ-011 Port B, output, DATA_W bits: read port B data.

Function
REQ-012 The storage SHALL be 2**ADDR_W registers of DATA_W bits each.
REQ-013 On a rising clk edge with rst_n=1, WE=1 and rW!=0, register[rW] SHALL take the value W.
REQ-014 With WE=0, no register SHALL change, whatever the values of rW and W.
REQ-015 Register 0 SHALL be hardwired to zero; writes to rW=0 SHALL be ignored, and a read of address 0 SHALL return 0.
REQ-016 A SHALL equal register[rA] combinationally, with zero latency.
REQ-017 B SHALL equal register[rB] combinationally, with zero latency.
REQ-018 The read ports SHALL be independent; rA=rB SHALL return identical data on A and B.
REQ-019 There SHALL be no write-to-read bypass; read/write collisions behave as follows:
- A read of rW in the same cycle as a write SHALL return the old value until the clock edge.
- After the clock edge the read SHALL return the new value in the same delta-settled time.
REQ-020 A write SHALL affect only the addressed register; all other registers SHALL hold their values.
REQ-021 X or Z on WE SHALL be treated as no write, in both simulation and synthesis intent.

Reset
REQ-022 While rst_n=0, all registers SHALL be cleared to 0 asynchronously, without waiting for a clock edge.
REQ-023 While rst_n=0, A and B SHALL therefore read 0 for every address.
REQ-024 Writes SHALL be blocked while rst_n=0.
REQ-025 The first write after reset deassertion SHALL occur on the first rising clk edge at which rst_n=1 and WE=1.
REQ-026 A reset asserted mid-operation SHALL discard any pending write in that cycle.

Structure
REQ-027 The DATA_W and ADDR_W defaults and the zero-register index constant SHALL live in a shared package.
REQ-028 The design SHALL consist of one module with no sub-modules: one storage array plus two read multiplexers.

Verification
REQ-029 Reset with rst_n=0, rA=1, rB=2 -> A=0x00000000 and B=0x00000000 immediately, without a clock edge.
REQ-030 WE=0, rW=1, W=0xFFFFFFFF, clock for 10 cycles -> A (rA=1) stays 0x00000000.
REQ-031 WE=1, rW=1, W=0xFFFFFFFF -> A=0xFFFFFFFF after the next rising edge, and B (rB=2) stays 0.
REQ-032 WE=1, rW=2, W=0x88888888 -> B=0x88888888 after the edge, and A (rA=1) still reads 0xFFFFFFFF.
REQ-033 WE=1, rW=0, W=0x88888888, rA=0 -> A=0x00000000 on every cycle.
REQ-034 With registers 1 and 2 loaded, pulse rst_n low between clock edges -> A and B return to 0 asynchronously, and the next write takes effect normally.
